// File: rtl/asip_pkg.sv
// Shared types and widths for the ASIP data-memory path.
// Owner tags, arbiter state and round-robin pointer encodings.
package asip_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 24;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_EXT  = 2'd2
  } owner_e;

  typedef enum logic {
    ARB_IDLE      = 1'b0,
    ARB_EXT_BURST = 1'b1
  } arb_state_e;

  typedef enum logic {
    RR_CORE = 1'b0,
    RR_EXT  = 1'b1
  } rr_e;

  // Tag pushed into the return pipe for one granted access.
  function automatic owner_e rd_owner(
    input logic cgnt,
    input logic cwe,
    input logic egnt,
    input logic ewe
  );
    owner_e t;
    t = OWN_NONE;
    if (cgnt && !cwe) t = OWN_CORE;
    if (egnt && !ewe) t = OWN_EXT;
    return t;
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Delay line of read-owner tags matching the memory read latency.
// The exiting tag selects which requester sees rvalid.
module rd_tag_pipe
  import asip_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  owner_e i_tag,
  output owner_e o_tag
);

  owner_e r_pipe [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pipe[i] <= OWN_NONE;
      end
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_tag = r_pipe[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: core load/store vs external loader.
// Round-robin in idle, locked bounded loader bursts, tagged read return.
module dmem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 24,
  parameter int MAX_BURST = 8,
  parameter int RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  input  logic              ext_last,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  import asip_pkg::*;

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BEAT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] BEAT_ONE = CNT_W'(1);

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  rr_e              r_rr;
  rr_e              w_rr_nxt;
  logic [CNT_W-1:0] r_beat;
  logic [CNT_W-1:0] w_beat_nxt;
  logic [CNT_W-1:0] w_beat_inc;
  logic             w_core_sel;
  logic             w_ext_sel;
  logic             w_core_gnt;
  logic             w_ext_gnt;
  owner_e           w_tag_in;
  owner_e           w_tag_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_rr    <= RR_CORE;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rr    <= w_rr_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  assign w_beat_inc = r_beat + BEAT_ONE;

  // Grant selection from state, pointer and requests.
  always_comb begin
    w_core_sel = 1'b0;
    w_ext_sel  = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        if (core_req && ext_req) begin
          w_core_sel = (r_rr == RR_CORE);
          w_ext_sel  = (r_rr == RR_EXT);
        end else begin
          w_core_sel = core_req;
          w_ext_sel  = ext_req;
        end
      end
      ARB_EXT_BURST: begin
        w_ext_sel  = ext_req;
        w_core_sel = core_req & ~ext_req;
      end
      default: begin
        w_core_sel = 1'b0;
        w_ext_sel  = 1'b0;
      end
    endcase
  end

  assign w_core_gnt = w_core_sel & ~rst;
  assign w_ext_gnt  = w_ext_sel & ~rst;

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr;
    w_beat_nxt  = r_beat;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_core_gnt) begin
          w_rr_nxt = RR_EXT;
        end
        if (w_ext_gnt) begin
          w_rr_nxt = RR_CORE;
          if (!ext_last) begin
            w_state_nxt = ARB_EXT_BURST;
            w_beat_nxt  = BEAT_ONE;
          end
        end
      end
      ARB_EXT_BURST: begin
        // Bubble-fill core grants leave the beat count alone.
        if (w_ext_gnt) begin
          w_beat_nxt = w_beat_inc;
          if (ext_last || (w_beat_inc == BEAT_MAX)) begin
            w_state_nxt = ARB_IDLE;
            w_rr_nxt    = RR_CORE;
            w_beat_nxt  = '0;
          end
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_rr_nxt    = RR_CORE;
        w_beat_nxt  = '0;
      end
    endcase
  end

  assign w_tag_in = rd_owner(w_core_gnt, core_we,
                             w_ext_gnt, ext_we);

  rd_tag_pipe #(
    .DEPTH (RD_LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  assign core_gnt    = w_core_gnt;
  assign ext_gnt     = w_ext_gnt;
  assign core_stall  = core_req & ~w_core_gnt;

  assign mem_addr  = w_ext_gnt ? ext_addr : core_addr;
  assign mem_wdata = w_ext_gnt ? ext_wdata : core_wdata;
  assign mem_we    = (w_core_gnt & core_we)
                   | (w_ext_gnt & ext_we);

  assign core_rvalid = (w_tag_out == OWN_CORE);
  assign ext_rvalid  = (w_tag_out == OWN_EXT);
  assign core_rdata  = mem_rdata;
  assign ext_rdata   = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a simple synchronous memory.
// Vector table plus burst, bubble-fill and reset-mid-read sequences.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we;
  logic [15:0] core_addr;
  logic [23:0] core_wdata;
  logic        core_gnt, core_stall;
  logic        core_rvalid;
  logic [23:0] core_rdata;
  logic        ext_req, ext_we, ext_last;
  logic [15:0] ext_addr;
  logic [23:0] ext_wdata;
  logic        ext_gnt, ext_rvalid;
  logic [23:0] ext_rdata;
  logic [15:0] mem_addr;
  logic [23:0] mem_wdata;
  logic        mem_we;
  logic [23:0] mem_rdata;

  logic [23:0] mem [1024];
  logic [23:0] r_rd_q;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W    (16),
    .DATA_W    (24),
    .MAX_BURST (8),
    .RD_LAT    (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_gnt    (core_gnt),
    .core_stall  (core_stall),
    .core_rvalid (core_rvalid),
    .core_rdata  (core_rdata),
    .ext_req     (ext_req),
    .ext_we      (ext_we),
    .ext_addr    (ext_addr),
    .ext_wdata   (ext_wdata),
    .ext_last    (ext_last),
    .ext_gnt     (ext_gnt),
    .ext_rvalid  (ext_rvalid),
    .ext_rdata   (ext_rdata),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata)
  );

  // Single-port memory, one cycle read latency, read-before-write.
  always @(posedge clk) begin
    r_rd_q <= mem[mem_addr[9:0]];
    if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
  end
  assign mem_rdata = r_rd_q;

  typedef struct {
    logic        cr, cw;
    logic [15:0] ca;
    logic        er, ew, el;
    logic [15:0] ea;
    logic [23:0] ed;
    logic        xcg, xcs, xeg, xwe;
    logic [15:0] xa;
    logic        xcrv, xerv;
    logic [23:0] xrd;
  } vec_t;

  function automatic vec_t mkv(
    input logic cr, cw, input logic [15:0] ca,
    input logic er, ew, el, input logic [15:0] ea,
    input logic [23:0] ed,
    input logic xcg, xcs, xeg, xwe,
    input logic [15:0] xa,
    input logic xcrv, xerv, input logic [23:0] xrd
  );
    vec_t v;
    v.cr = cr; v.cw = cw; v.ca = ca;
    v.er = er; v.ew = ew; v.el = el;
    v.ea = ea; v.ed = ed;
    v.xcg = xcg; v.xcs = xcs;
    v.xeg = xeg; v.xwe = xwe; v.xa = xa;
    v.xcrv = xcrv; v.xerv = xerv; v.xrd = xrd;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  task automatic drive(
    input logic cr, cw, input logic [15:0] ca,
    input logic er, ew, el, input logic [15:0] ea,
    input logic [23:0] ed
  );
    core_req = cr; core_we = cw; core_addr = ca;
    core_wdata = 24'h0;
    ext_req = er; ext_we = ew; ext_last = el;
    ext_addr = ea; ext_wdata = ed;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  vec_t tbl [15];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 24'h0;
    mem[16'h10] = 24'hABCDEF;
    mem[16'h20] = 24'h123456;
    mem[16'h30] = 24'h654321;
    mem[16'h40] = 24'h0A0B0C;
    mem[16'h50] = 24'h111111;

    //            cr cw ca     er ew el ea      ed
    //            cg cs eg we  addr    crv erv rd
    tbl[0]  = mkv(0,0,16'h0, 0,0,0,16'h0, 24'h0,
                  0,0,0,0, 16'h0, 0,0,24'h0);
    tbl[1]  = mkv(1,0,16'h10, 1,0,1,16'h20, 24'h0,
                  1,0,0,0, 16'h10, 0,0,24'h0);
    tbl[2]  = mkv(1,0,16'h30, 1,0,1,16'h20, 24'h0,
                  0,1,1,0, 16'h20, 1,0,24'hABCDEF);
    tbl[3]  = mkv(1,0,16'h30, 1,0,1,16'h40, 24'h0,
                  1,0,0,0, 16'h30, 0,1,24'h123456);
    tbl[4]  = mkv(1,0,16'h10, 1,0,1,16'h40, 24'h0,
                  0,1,1,0, 16'h40, 1,0,24'h654321);
    tbl[5]  = mkv(0,0,16'h0, 0,0,0,16'h0, 24'h0,
                  0,0,0,0, 16'h0, 0,1,24'h0A0B0C);
    tbl[6]  = mkv(1,0,16'h10, 0,0,0,16'h0, 24'h0,
                  1,0,0,0, 16'h10, 0,0,24'h0);
    tbl[7]  = mkv(0,0,16'h0, 0,0,0,16'h0, 24'h0,
                  0,0,0,0, 16'h0, 1,0,24'hABCDEF);
    tbl[8]  = mkv(1,0,16'h50, 1,1,0,16'h100, 24'hC0FFE0,
                  0,1,1,1, 16'h100, 0,0,24'h0);
    tbl[9]  = mkv(1,0,16'h50, 1,1,0,16'h101, 24'hC0FFE1,
                  0,1,1,1, 16'h101, 0,0,24'h0);
    tbl[10] = mkv(1,0,16'h50, 1,1,0,16'h102, 24'hC0FFE2,
                  0,1,1,1, 16'h102, 0,0,24'h0);
    tbl[11] = mkv(1,0,16'h50, 1,1,1,16'h103, 24'hC0FFE3,
                  0,1,1,1, 16'h103, 0,0,24'h0);
    tbl[12] = mkv(1,0,16'h50, 0,0,0,16'h0, 24'h0,
                  1,0,0,0, 16'h50, 0,0,24'h0);
    tbl[13] = mkv(1,0,16'h101, 0,0,0,16'h0, 24'h0,
                  1,0,0,0, 16'h101, 1,0,24'h111111);
    tbl[14] = mkv(0,0,16'h0, 0,0,0,16'h0, 24'h0,
                  0,0,0,0, 16'h0, 1,0,24'hC0FFE1);

    rst = 1'b1;
    drive(1,0,16'h10, 1,0,1,16'h20, 24'h0);
    #3;
    chk("rst core_gnt", 32'(core_gnt), 32'd0);
    chk("rst ext_gnt", 32'(ext_gnt), 32'd0);
    chk("rst core_rvalid", 32'(core_rvalid), 32'd0);
    chk("rst ext_rvalid", 32'(ext_rvalid), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    step();
    drive(0,0,16'h0, 0,0,0,16'h0, 24'h0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      step();
      drive(tbl[i].cr, tbl[i].cw, tbl[i].ca,
            tbl[i].er, tbl[i].ew, tbl[i].el,
            tbl[i].ea, tbl[i].ed);
      #1;
      chk($sformatf("v%0d core_gnt", i),
          32'(core_gnt), 32'(tbl[i].xcg));
      chk($sformatf("v%0d core_stall", i),
          32'(core_stall), 32'(tbl[i].xcs));
      chk($sformatf("v%0d ext_gnt", i),
          32'(ext_gnt), 32'(tbl[i].xeg));
      chk($sformatf("v%0d mem_we", i),
          32'(mem_we), 32'(tbl[i].xwe));
      chk($sformatf("v%0d mem_addr", i),
          32'(mem_addr), 32'(tbl[i].xa));
      chk($sformatf("v%0d core_rvalid", i),
          32'(core_rvalid), 32'(tbl[i].xcrv));
      chk($sformatf("v%0d ext_rvalid", i),
          32'(ext_rvalid), 32'(tbl[i].xerv));
      if (tbl[i].xwe)
        chk($sformatf("v%0d mem_wdata", i),
            32'(mem_wdata), 32'(tbl[i].ed));
      if (tbl[i].xcrv)
        chk($sformatf("v%0d core_rdata", i),
            32'(core_rdata), 32'(tbl[i].xrd));
      if (tbl[i].xerv)
        chk($sformatf("v%0d ext_rdata", i),
            32'(ext_rdata), 32'(tbl[i].xrd));
    end

    // Unterminated burst capped at 8 beats, then core, then ext.
    for (int i = 0; i < 10; i++) begin
      step();
      drive(1,0,16'h10, 1,1,0,16'(16'h200 + i),
            24'(i));
      #1;
      chk($sformatf("cap%0d ext_gnt", i),
          32'(ext_gnt), 32'(i != 8));
      chk($sformatf("cap%0d core_gnt", i),
          32'(core_gnt), 32'(i == 8));
      if (i == 9)
        chk("cap core_rvalid", 32'(core_rvalid), 32'd1);
    end
    step();
    drive(0,0,16'h0, 1,1,1,16'h20A, 24'h0);
    #1;
    chk("cap close ext_gnt", 32'(ext_gnt), 32'd1);

    // Bubble fill: core reads while loader idles mid-burst.
    step();
    drive(0,0,16'h0, 1,1,0,16'h300, 24'h5);
    #1;
    chk("bub open ext_gnt", 32'(ext_gnt), 32'd1);
    step();
    drive(1,0,16'h10, 0,0,0,16'h0, 24'h0);
    #1;
    chk("bub1 core_gnt", 32'(core_gnt), 32'd1);
    chk("bub1 core_stall", 32'(core_stall), 32'd0);
    step();
    drive(1,0,16'h20, 0,0,0,16'h0, 24'h0);
    #1;
    chk("bub2 core_gnt", 32'(core_gnt), 32'd1);
    chk("bub2 core_rvalid", 32'(core_rvalid), 32'd1);
    chk("bub2 core_rdata", 32'(core_rdata),
        32'h00ABCDEF);
    for (int k = 0; k < 7; k++) begin
      step();
      drive(1,0,16'h10, 1,1,0,16'(16'h301 + k),
            24'h0);
      #1;
      chk($sformatf("bub beat%0d ext_gnt", k + 2),
          32'(ext_gnt), 32'd1);
      chk($sformatf("bub beat%0d core_gnt", k + 2),
          32'(core_gnt), 32'd0);
      if (k == 0) begin
        chk("bub3 core_rvalid", 32'(core_rvalid), 32'd1);
        chk("bub3 core_rdata", 32'(core_rdata),
            32'h00123456);
      end
    end
    step();
    #1;
    chk("bub end core_gnt", 32'(core_gnt), 32'd1);
    chk("bub end ext_gnt", 32'(ext_gnt), 32'd0);
    step();
    drive(0,0,16'h0, 0,0,0,16'h0, 24'h0);
    #1;
    chk("bub end core_rvalid", 32'(core_rvalid), 32'd1);
    chk("bub end core_rdata", 32'(core_rdata),
        32'h00ABCDEF);

    // Reset while an ext read is in flight.
    step();
    drive(0,0,16'h0, 1,0,1,16'h20, 24'h0);
    #1;
    chk("rmr ext_gnt", 32'(ext_gnt), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    core_req = 1'b1;
    #1;
    chk("rmr rst ext_rvalid", 32'(ext_rvalid), 32'd0);
    chk("rmr rst core_gnt", 32'(core_gnt), 32'd0);
    chk("rmr rst ext_gnt", 32'(ext_gnt), 32'd0);
    step();
    drive(0,0,16'h0, 0,0,0,16'h0, 24'h0);
    #1;
    rst = 1'b0;
    #1;
    chk("rmr rel ext_rvalid", 32'(ext_rvalid), 32'd0);
    chk("rmr rel core_rvalid", 32'(core_rvalid), 32'd0);
    step();
    drive(1,0,16'h30, 1,0,1,16'h40, 24'h0);
    #1;
    chk("rmr cont core_gnt", 32'(core_gnt), 32'd1);
    chk("rmr cont ext_gnt", 32'(ext_gnt), 32'd0);
    chk("rmr cont ext_rvalid", 32'(ext_rvalid), 32'd0);
    step();
    drive(0,0,16'h0, 0,0,0,16'h0, 24'h0);
    #1;
    chk("rmr ret core_rvalid", 32'(core_rvalid), 32'd1);
    chk("rmr ret core_rdata", 32'(core_rdata),
        32'h00654321);
    chk("rmr ret ext_rvalid", 32'(ext_rvalid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port synchronous data memory between the ASIP core load/store port and an external loader (DMA/UART image fill). Sits between the core top and the data memory.
- Grants at most one access per cycle.
- Supports locked loader bursts with a bounded length.
- Returns read data to the correct requester after the memory read latency.
- Generates the core stall.

Parameters:
ADDR_W, 16, address width (matches core PC/ALU result width)
DATA_W, 24, data word width (matches core word width)
MAX_BURST, 8, maximum loader beats per locked burst (≥2)
RD_LAT, 1, memory read latency in cycles (≥1)

Ports:
clk  in  1  single clock; all state changes on rising edge
rst  in  1  asynchronous, active-high reset
core_req  in  1  core access request
core_we  in  1  core write enable (0 = read)
core_addr  in  ADDR_W  core address
core_wdata  in  DATA_W  core write data
core_gnt  out  1  core access issued this cycle
core_stall  out  1  core_req & ~core_gnt
core_rvalid  out  1  core read data valid
core_rdata  out  DATA_W  core read data
ext_req  in  1  loader access request
ext_we  in  1  loader write enable
ext_addr  in  ADDR_W  loader address
ext_wdata  in  DATA_W  loader write data
ext_last  in  1  final beat of loader burst
ext_gnt  out  1  loader access issued this cycle
ext_rvalid  out  1  loader read data valid
ext_rdata  out  DATA_W  loader read data
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_we  out  1  memory write strobe
mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after address

Behaviour:
- Transfer rule: a transfer occurs when req & gnt in the same cycle. Grants are combinational from state, rr_ptr and the reqs. core_gnt & ext_gnt is never 1.
- Memory mux: mem_addr/mem_wdata follow the granted requester (core when none is granted). mem_we = (core_gnt & core_we) | (ext_gnt & ext_we).
- State IDLE:
  - One requester: grant it.
  - Both requesting: grant the one selected by rr_ptr.
  - On every grant, rr_ptr points to the other requester.
  - ext granted with ext_last=0 → EXT_BURST, beat_cnt=1.
- State EXT_BURST:
  - ext_gnt = ext_req. The core is granted only in cycles where ext_req=0 (bubble fill); beat_cnt does not advance in those cycles.
  - Each ext transfer increments beat_cnt.
  - An ext transfer with ext_last=1, or with beat_cnt+1 == MAX_BURST, → IDLE with rr_ptr=CORE.
- Read return:
  - Each read transfer pushes an owner tag (CORE/EXT) into an RD_LAT-deep pipe; writes push NONE.
  - When the tag exits the pipe, that requester's rvalid is 1 for one cycle.
  - core_rdata and ext_rdata both carry mem_rdata unregistered; they are meaningful only while the matching rvalid is high.
- Back-to-back: reads on consecutive cycles from alternating requesters each return in order, one per cycle, with no loss.
- Address wrap: none; addresses pass through unchanged.
- Reset (async, any time including mid-burst):
  - state=IDLE, beat_cnt=0, rr_ptr=CORE, tag pipe cleared.
  - core_rvalid=ext_rvalid=0 immediately.
  - In-flight reads are dropped; no rvalid is produced for them after release.
  - Grants are 0 while rst=1.
- Latency: grant is 0-cycle. Read data arrives RD_LAT cycles after the transfer. A write completes in its grant cycle.

Decomposition:
- Package asip_pkg:
  - ADDR_W and DATA_W constants.
  - owner_e {OWN_NONE, OWN_CORE, OWN_EXT}.
  - arb_state_e {ARB_IDLE, ARB_EXT_BURST}.
- Sub-module rd_tag_pipe: RD_LAT-deep shift register of owner_e with async reset. Outputs the exiting tag.

Test Plan:
- Core-only read (core_req=1, we=0, addr=0x0010, mem returns 0xABCDEF) → core_gnt=1 in cycle 0, core_rvalid=1 with core_rdata=0xABCDEF in cycle 1, core_stall=0 throughout.
- Simultaneous single requests right after reset (both req, ext_last=1) → core granted in cycle 0, ext in cycle 1. core_stall=0, then ext waits one cycle. Repeating the pattern alternates grants.
- Ext burst of 4 writes (addr 0x0100..0x0103, ext_last on beat 4) with core_req held → core_stall=1 for 4 cycles, mem_we=1 for 4 cycles, core granted in cycle 5.
- Ext burst without ext_last, MAX_BURST=8, both requesting continuously → ext gets exactly 8 beats, then the core gets 1 grant, then ext re-arbitrates.
- Bubble fill: during EXT_BURST, ext_req drops for 2 cycles while the core requests reads → core gets 2 grants, beat_cnt unchanged, and the matching core_rvalid pulses appear one cycle later.
- Reset mid-read: ext read granted, rst pulses before the return cycle → no ext_rvalid. State is IDLE and the core wins the next contention.
